// File: rtl/margin_scan_pkg.sv
// Shared types and defaults for the margin-scan pass sequencer.
package margin_scan_pkg;

    localparam int unsigned N_MAX_DEFAULT    = 1024;
    localparam int unsigned PIPE_LAT_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } scan_state_e;

endpackage

// File: rtl/scan_delay_line.sv
// Fixed-depth shift register aligning the read strobe with data arriving at the datapath.
module scan_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/margin_scan_ctrl.sv
// Sequencer for one margin-sampling pass: issues score-memory reads, then waits
// out the memory/datapath latency before signalling completion.
module margin_scan_ctrl
    import margin_scan_pkg::*;
#(
    parameter int unsigned N_MAX      = N_MAX_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 11,
    parameter int unsigned PIPE_LAT   = PIPE_LAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  dp_en,
    output logic                  dp_last,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

    scan_state_e           r_state;
    scan_state_e           w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len_eff;
    logic [LEN_WIDTH-1:0]  w_len_eff;
    logic [DRAIN_W-1:0]    r_drain;
    logic                  r_aborted;
    logic                  w_start_acc;
    logic                  w_abort_take;
    logic                  w_last_addr;
    logic                  w_drain_end;
    logic                  w_rd_en;
    logic [1:0]            w_dp;

    assign w_len_eff    = (len > LEN_WIDTH'(N_MAX)) ? LEN_WIDTH'(N_MAX) : len;
    assign w_abort_take = abort && (r_state != IDLE);
    assign w_start_acc  = start && !abort && (r_state == IDLE);
    // Compared in LEN_WIDTH so a full N_MAX pass terminates at the top address without wrap.
    assign w_last_addr  = (LEN_WIDTH'(r_addr) == (r_len_eff - LEN_WIDTH'(1)));
    assign w_drain_end  = (r_drain == DRAIN_W'(PIPE_LAT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort_take) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_start_acc) w_next = (w_len_eff == '0) ? DONE : ISSUE;
                ISSUE: if (!stall && w_last_addr) w_next = DRAIN;
                DRAIN: if (w_drain_end) w_next = DONE;
                DONE:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_en = (r_state == ISSUE) && !stall;
        busy    = (r_state != IDLE);
        done    = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_len_eff <= '0;
            r_drain   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_take;
            r_drain   <= (r_state == DRAIN && !w_abort_take) ? r_drain + DRAIN_W'(1) : '0;
            if (w_abort_take) begin
                r_addr <= '0;
            end else if (w_start_acc) begin
                r_len_eff <= w_len_eff;
                r_addr    <= '0;
            end else if (w_rd_en) begin
                r_addr <= w_last_addr ? '0 : r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    scan_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (2)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_abort_take),
        .i_d   ({w_rd_en, w_rd_en && w_last_addr}),
        .o_q   (w_dp)
    );

    assign rd_en   = w_rd_en;
    assign rd_addr = r_addr;
    assign dp_en   = w_dp[1];
    assign dp_last = w_dp[0];
    assign aborted = r_aborted;

endmodule
